route_interlock: RTL and testbench
==================================

// Module: route_interlock
// PURPOSE
//  Parametrised station interlocking: holds one route per approach track (L_IN, L_OUT, R_IN, R_OUT) into N_STN
//  station tracks. Accepts route set/cancel requests, rejects conflicting ones, times point movement, and drives
//  per-route clear signals. Releases each route automatically once its train has passed.
//  Sits between the key/switch front end and the GPIO signal/point drivers.
// PARAMETERS
//  N_STN        4    station tracks; even, >=2; lower half is left-near, upper half is right-near
//  POINT_CYC    8    cycles in SETTING before the signal clears (point throw time)
//  RELEASE_CYC  16   cycles in RELEASING before the slot returns to IDLE
//  APPROACH_TO  1024 LOCKED timeout in cycles (used only with ROUTE_TIMEOUT_EN)
// PORTS
//  CLOCK_50   in   1          system clock
//  RESET      in   1          asynchronous, active-high reset
//  req_valid  in   1          request strobe
//  req_ready  out  1          request accepted on a cycle where req_valid && req_ready
//  req_cancel in   1          1 = cancel the route in req_slot; 0 = set a route
//  req_slot   in   2          0 = L_IN, 1 = L_OUT, 2 = R_IN, 3 = R_OUT
//  req_stn    in   STN_W      station track index; STN_W = max(1, clog2(N_STN))
//  rsp_valid  out  1          one-cycle response pulse
//  rsp_ok     out  1          1 = request granted; qualified by rsp_valid
//  occ        in   4          per-slot route-path track-circuit occupancy, 1 = occupied
//  sig_clear  out  4          per-slot signal proceed aspect
//  slot_busy  out  4          slot state != IDLE
//  slot_stn   out  4*STN_W    station index held by each slot
// BEHAVIOUR
//  Reset: all slots IDLE; sig_clear, slot_busy, slot_stn, rsp_valid and rsp_ok = 0; req_ready = 1.
//   An assertion mid-operation aborts all routes and counters at once.
//  Handshake: request accepted at edge k; rsp_valid = 1 during cycle k+1. req_ready = !rsp_valid, so at most one
//   request is in flight.
//  Conflict rule: slots A and B conflict if they are on the same side and any of the following holds:
//   - same station track;
//   - opposite directions and the outbound slot's station is in that side's near half
//     (left near = 0..N_STN/2-1; right near = N_STN/2..N_STN-1).
//   Different sides never conflict. Every non-IDLE slot holds its route.
//  Set request: rsp_ok = 1 only if all of the following hold: req_slot is IDLE, req_stn < N_STN, and there is no
//   conflict with any non-IDLE slot. On grant the slot enters SETTING at k+1 and slot_stn is latched.
//   Otherwise rsp_ok = 0 and no state changes.
//  Slot FSM:
//   - IDLE -> SETTING on grant.
//   - SETTING: counter counts POINT_CYC cycles; it freezes while occ = 1. Then -> LOCKED with sig_clear = 1.
//   - LOCKED -> OCCUPIED when occ rises; sig_clear drops in the same cycle as the transition edge.
//   - OCCUPIED -> RELEASING when occ falls.
//   - RELEASING: counts RELEASE_CYC cycles, then -> IDLE.
//  Cancel request:
//   - Slot in SETTING or LOCKED: rsp_ok = 1, sig_clear = 0 next cycle, slot -> RELEASING.
//   - Slot in IDLE, OCCUPIED or RELEASING: rsp_ok = 0, no change.
//  Simultaneous events: if occ rises on the same edge a cancel is granted, the cancel wins (-> RELEASING).
//   A request arbitrated against a slot that transitions that same edge uses the pre-edge state.
// CONFIGURATION
//  ROUTE_TIMEOUT_EN defined:
//   - A slot in LOCKED for APPROACH_TO cycles without occ -> RELEASING with sig_clear = 0.
//   - The counter restarts on entry to LOCKED.
//  ROUTE_TIMEOUT_EN undefined: LOCKED is held indefinitely.
// STRUCTURE
//  Package train_ctl_pkg holds:
//   - slot_e (L_IN, L_OUT, R_IN, R_OUT) and state_e (IDLE, SETTING, LOCKED, OCCUPIED, RELEASING);
//   - function conflicts(slotA, stnA, slotB, stnB, n_stn).
//  Sub-module route_slot: per-slot FSM and counter, instantiated 4x.
//  The top level holds the arbiter, conflict check and response register.
// TESTING
//  - Set L_IN->stn1 -> rsp_ok = 1 at k+1; sig_clear[0] = 1 after 8 SETTING cycles; slot_stn[0] = 1.
//  - With L_IN->stn3 held, set L_OUT<-stn0 -> rsp_ok = 0 (near outbound crossing).
//    Then L_OUT<-stn2 -> rsp_ok = 1.
//  - R_IN->stn2 held, set R_OUT<-stn2 -> rejected (same station). L_IN->stn2 -> rejected.
//    L_IN->stn1 -> granted.
//  - LOCKED slot 0: occ[0] = 1 -> sig_clear[0] = 0 the next cycle. occ[0] = 0 -> slot_busy[0] stays 1 for 16
//    cycles, then 0.
//  - Cancel slot in SETTING -> rsp_ok = 1, released. Cancel IDLE slot -> rsp_ok = 0. req_stn = 4 with N_STN = 4
//    -> rejected.
//  - RESET pulsed while two routes are LOCKED -> all outputs 0 asynchronously. With ROUTE_TIMEOUT_EN: LOCKED and
//    no occ for 1024 cycles -> sig_clear = 0.

Source files
------------

// File: rtl/train_ctl_pkg.sv
// Shared types and the route conflict rule for the station interlocking.
package train_ctl_pkg;

    typedef enum logic [1:0] {L_IN = 2'd0, L_OUT = 2'd1, R_IN = 2'd2, R_OUT = 2'd3} slot_e;

    typedef enum logic [2:0] {IDLE, SETTING, LOCKED, OCCUPIED, RELEASING} state_e;

    // Bit 1 of a slot is its side (0 = left), bit 0 its direction (1 = outbound).
    function automatic logic conflicts(input slot_e slot_a, input int stn_a,
                                       input slot_e slot_b, input int stn_b,
                                       input int n_stn);
        logic [1:0] a;
        logic [1:0] b;
        int         out_stn;
        logic       hit;
        a   = slot_a;
        b   = slot_b;
        hit = 1'b0;
        if (a[1] == b[1]) begin
            if (stn_a == stn_b) begin
                hit = 1'b1;
            end else if (a[0] != b[0]) begin
                out_stn = a[0] ? stn_a : stn_b;
                // An outbound route from the near half crosses the inbound throat.
                hit = a[1] ? (out_stn >= n_stn / 2) : (out_stn < n_stn / 2);
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/route_slot.sv
// One route slot: state machine, point/release/approach counter and latched station index.
// The approach timeout in LOCKED is built only when ROUTE_TIMEOUT_EN is defined.
module route_slot
    import train_ctl_pkg::*;
#(
    parameter int STN_W       = 2,
    parameter int POINT_CYC   = 8,
    parameter int RELEASE_CYC = 16,
    parameter int APPROACH_TO = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             cancel,
    input  logic             occ,
    input  logic [STN_W-1:0] new_stn,
    output state_e           state,
    output logic [STN_W-1:0] stn,
    output logic             sig_clear
);

    localparam int MAX_A = (POINT_CYC > RELEASE_CYC) ? POINT_CYC : RELEASE_CYC;
    localparam int MAX_C = (MAX_A > APPROACH_TO) ? MAX_A : APPROACH_TO;
    localparam int CNT_W = $clog2(MAX_C + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STN_W-1:0]   stn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (set && state_q == IDLE) stn_q <= new_stn;
        end
    end

    // Cancel is only issued by the arbiter for SETTING/LOCKED and outranks occupancy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (set) begin
                    state_d = SETTING;
                    cnt_d   = '0;
                end
            end
            SETTING: begin
                if (cancel) begin
                    state_d = RELEASING;
                    cnt_d   = '0;
                end else if (!occ) begin
                    if (cnt_q == CNT_W'(POINT_CYC - 1)) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (cancel) begin
                    state_d = RELEASING;
                    cnt_d   = '0;
                end else if (occ) begin
                    state_d = OCCUPIED;
`ifdef ROUTE_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(APPROACH_TO - 1)) begin
                    state_d = RELEASING;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            OCCUPIED: begin
                if (!occ) begin
                    state_d = RELEASING;
                    cnt_d   = '0;
                end
            end
            RELEASING: begin
                if (cnt_q == CNT_W'(RELEASE_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign state     = state_q;
    assign stn       = stn_q;
    assign sig_clear = (state_q == LOCKED);

endmodule

// File: rtl/route_interlock.sv
// Station interlocking top: request arbiter, conflict check, response register and four route slots.
// Optional approach timeout in the slots is enabled with ROUTE_TIMEOUT_EN.
module route_interlock
    import train_ctl_pkg::*;
#(
    parameter int  N_STN       = 4,
    parameter int  POINT_CYC   = 8,
    parameter int  RELEASE_CYC = 16,
    parameter int  APPROACH_TO = 1024,
    localparam int STN_W       = (N_STN > 1) ? $clog2(N_STN) : 1
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_cancel,
    input  logic [1:0]         req_slot,
    input  logic [STN_W-1:0]   req_stn,
    output logic               rsp_valid,
    output logic               rsp_ok,
    input  logic [3:0]         occ,
    output logic [3:0]         sig_clear,
    output logic [3:0]         slot_busy,
    output logic [4*STN_W-1:0] slot_stn
);

    state_e                  st [4];
    logic [3:0][STN_W-1:0]   stn_q;
    logic [3:0]              set_v;
    logic [3:0]              cancel_v;
    logic                    accept;
    logic                    grant_ok;
    state_e                  sel_state;

    assign req_ready = !rsp_valid;
    assign accept    = req_valid && req_ready;

    // Arbitration sees pre-edge slot states, so same-edge slot transitions do not affect it.
    always_comb begin
        sel_state = st[req_slot];
        grant_ok  = 1'b0;
        if (req_cancel) begin
            grant_ok = (sel_state == SETTING) || (sel_state == LOCKED);
        end else begin
            grant_ok = (sel_state == IDLE) && (int'(req_stn) < N_STN);
            for (int i = 0; i < 4; i++) begin
                if (st[i] != IDLE &&
                    conflicts(slot_e'(req_slot), int'(req_stn), slot_e'(i[1:0]), int'(stn_q[i]), N_STN))
                    grant_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            rsp_valid <= 1'b0;
            rsp_ok    <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_ok    <= accept && grant_ok;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_slot
        assign set_v[g]    = accept && grant_ok && !req_cancel && (req_slot == 2'(g));
        assign cancel_v[g] = accept && grant_ok &&  req_cancel && (req_slot == 2'(g));
        assign slot_busy[g] = (st[g] != IDLE);

        route_slot #(
            .STN_W      (STN_W),
            .POINT_CYC  (POINT_CYC),
            .RELEASE_CYC(RELEASE_CYC),
            .APPROACH_TO(APPROACH_TO)
        ) u_slot (
            .clk      (CLOCK_50),
            .rst      (RESET),
            .set      (set_v[g]),
            .cancel   (cancel_v[g]),
            .occ      (occ[g]),
            .new_stn  (req_stn),
            .state    (st[g]),
            .stn      (stn_q[g]),
            .sig_clear(sig_clear[g])
        );
    end

    assign slot_stn = stn_q;

endmodule

// File: tb/tb_route_interlock.sv
// Directed bench for route_interlock (N_STN = 4); the approach timeout case runs when ROUTE_TIMEOUT_EN is defined.
module tb_route_interlock;

    localparam int N_STN = 4;
    localparam int STN_W = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_cancel = 1'b0;
    logic [1:0]         req_slot = '0;
    logic [STN_W-1:0]   req_stn = '0;
    logic               rsp_valid;
    logic               rsp_ok;
    logic [3:0]         occ = '0;
    logic [3:0]         sig_clear;
    logic [3:0]         slot_busy;
    logic [4*STN_W-1:0] slot_stn;

    int checks = 0;
    int failures = 0;

    route_interlock #(.N_STN(N_STN)) dut (
        .CLOCK_50(clk), .RESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cancel(req_cancel),
        .req_slot(req_slot), .req_stn(req_stn),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
        .occ(occ), .sig_clear(sig_clear), .slot_busy(slot_busy), .slot_stn(slot_stn)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; occ = '0; req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    // Issue one request; returns the response seen in the cycle after acceptance.
    task automatic do_req(input logic c, input logic [1:0] s, input logic [STN_W-1:0] n,
                          output logic rv, output logic ok, output logic rdy);
        @(negedge clk);
        req_valid = 1'b1; req_cancel = c; req_slot = s; req_stn = n;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        rv = rsp_valid; ok = rsp_ok; rdy = req_ready;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (sig_clear !== 4'h0) begin failures++; $display("FAIL reset_sig got=%h exp=0", sig_clear); end
        checks++; if (slot_busy !== 4'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", slot_busy); end
        checks++; if (slot_stn !== 8'h00) begin failures++; $display("FAIL reset_stn got=%h exp=0", slot_stn); end
        checks++; if (rsp_valid !== 1'b0 || rsp_ok !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%b%b exp=00", rsp_valid, rsp_ok); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_set_and_pass();
        logic rv, ok, rdy;
        do_reset();
        do_req(1'b0, 2'd0, 2'd1, rv, ok, rdy);
        checks++; if (rv !== 1'b1 || ok !== 1'b1) begin failures++; $display("FAIL set_rsp got=%b%b exp=11", rv, ok); end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL ready_in_rsp got=%b exp=0", rdy); end
        checks++; if (slot_busy[0] !== 1'b1 || sig_clear[0] !== 1'b0) begin failures++; $display("FAIL setting_state got=%b%b exp=10", slot_busy[0], sig_clear[0]); end
        cyc(7);
        checks++; if (sig_clear[0] !== 1'b0) begin failures++; $display("FAIL sig_early got=%b exp=0", sig_clear[0]); end
        cyc(1);
        checks++; if (sig_clear[0] !== 1'b1) begin failures++; $display("FAIL sig_locked got=%b exp=1", sig_clear[0]); end
        checks++; if (slot_stn[1:0] !== 2'd1) begin failures++; $display("FAIL slot_stn got=%0d exp=1", slot_stn[1:0]); end
        occ[0] = 1'b1;
        cyc(1);
        checks++; if (sig_clear[0] !== 1'b0 || slot_busy[0] !== 1'b1) begin failures++; $display("FAIL occupied got=%b%b exp=01", sig_clear[0], slot_busy[0]); end
        do_req(1'b1, 2'd0, 2'd0, rv, ok, rdy);
        checks++; if (rv !== 1'b1 || ok !== 1'b0) begin failures++; $display("FAIL cancel_occupied got=%b%b exp=10", rv, ok); end
        occ[0] = 1'b0;
        begin
            int n = 0;
            while (n < 40) begin
                cyc(1);
                if (slot_busy[0] !== 1'b1) break;
                n++;
            end
            checks++; if (n != 16) begin failures++; $display("FAIL release_len got=%0d exp=16", n); end
        end
    endtask

    task automatic test_conflicts();
        logic rv, ok, rdy;
        do_reset();
        do_req(1'b0, 2'd0, 2'd3, rv, ok, rdy);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lin3 got=%b exp=1", ok); end
        do_req(1'b0, 2'd1, 2'd0, rv, ok, rdy);
        checks++; if (ok !== 1'b0) begin failures++; $display("FAIL lout0_near got=%b exp=0", ok); end
        do_req(1'b0, 2'd1, 2'd2, rv, ok, rdy);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lout2 got=%b exp=1", ok); end
        do_req(1'b0, 2'd2, 2'd2, rv, ok, rdy);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rin2_other_side got=%b exp=1", ok); end
        do_req(1'b0, 2'd3, 2'd2, rv, ok, rdy);
        checks++; if (ok !== 1'b0) begin failures++; $display("FAIL rout2_same got=%b exp=0", ok); end
        do_req(1'b0, 2'd3, 2'd3, rv, ok, rdy);
        checks++; if (ok !== 1'b0) begin failures++; $display("FAIL rout3_near got=%b exp=0", ok); end
        do_req(1'b0, 2'd3, 2'd1, rv, ok, rdy);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rout1_far got=%b exp=1", ok); end
        do_req(1'b1, 2'd0, 2'd0, rv, ok, rdy);
        checks++; if (ok !== 1'b1 || sig_clear[0] !== 1'b0) begin failures++; $display("FAIL cancel_lin got=%b%b exp=10", ok, sig_clear[0]); end
        do_req(1'b0, 2'd0, 2'd1, rv, ok, rdy);
        checks++; if (ok !== 1'b0) begin failures++; $display("FAIL lin_releasing got=%b exp=0", ok); end
        cyc(20);
        do_req(1'b0, 2'd0, 2'd2, rv, ok, rdy);
        checks++; if (ok !== 1'b0) begin failures++; $display("FAIL lin2_same got=%b exp=0", ok); end
        do_req(1'b0, 2'd0, 2'd1, rv, ok, rdy);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lin1 got=%b exp=1", ok); end
    endtask

    task automatic test_cancel();
        logic rv, ok, rdy;
        do_reset();
        do_req(1'b1, 2'd3, 2'd0, rv, ok, rdy);
        checks++; if (rv !== 1'b1 || ok !== 1'b0) begin failures++; $display("FAIL cancel_idle got=%b%b exp=10", rv, ok); end
        do_req(1'b0, 2'd3, 2'd1, rv, ok, rdy);
        do_req(1'b1, 2'd3, 2'd0, rv, ok, rdy);
        checks++; if (ok !== 1'b1 || slot_busy[3] !== 1'b1) begin failures++; $display("FAIL cancel_setting got=%b%b exp=11", ok, slot_busy[3]); end
        cyc(20);
        checks++; if (slot_busy[3] !== 1'b0 || sig_clear[3] !== 1'b0) begin failures++; $display("FAIL cancel_released got=%b%b exp=00", slot_busy[3], sig_clear[3]); end
        // Cancel coinciding with the train arriving: release must still complete with occ held.
        do_req(1'b0, 2'd0, 2'd0, rv, ok, rdy);
        cyc(10);
        @(negedge clk);
        occ[0] = 1'b1; req_valid = 1'b1; req_cancel = 1'b1; req_slot = 2'd0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_ok !== 1'b1) begin failures++; $display("FAIL cancel_race_ok got=%b exp=1", rsp_ok); end
        cyc(20);
        checks++; if (slot_busy[0] !== 1'b0) begin failures++; $display("FAIL cancel_race_idle got=%b exp=0", slot_busy[0]); end
        occ[0] = 1'b0;
    endtask

    task automatic test_point_freeze();
        logic rv, ok, rdy;
        int n;
        do_reset();
        do_req(1'b0, 2'd1, 2'd3, rv, ok, rdy);
        occ[1] = 1'b1;
        cyc(5);
        occ[1] = 1'b0;
        n = 0;
        while (sig_clear[1] !== 1'b1 && n < 30) begin cyc(1); n++; end
        checks++; if (n != 8) begin failures++; $display("FAIL freeze_len got=%0d exp=8", n); end
    endtask

    task automatic test_async_reset();
        logic rv, ok, rdy;
        do_reset();
        do_req(1'b0, 2'd0, 2'd1, rv, ok, rdy);
        do_req(1'b0, 2'd2, 2'd2, rv, ok, rdy);
        cyc(12);
        checks++; if (sig_clear !== 4'b0101) begin failures++; $display("FAIL two_locked got=%b exp=0101", sig_clear); end
        #2 rst = 1'b1;
        #1;
        checks++; if (sig_clear !== 4'h0 || slot_busy !== 4'h0) begin failures++; $display("FAIL async_rst got=%h/%h exp=0/0", sig_clear, slot_busy); end
        checks++; if (slot_stn !== 8'h00) begin failures++; $display("FAIL async_rst_stn got=%h exp=0", slot_stn); end
        @(negedge clk); rst = 1'b0;
    endtask

`ifdef ROUTE_TIMEOUT_EN
    task automatic test_timeout();
        logic rv, ok, rdy;
        int n;
        do_reset();
        do_req(1'b0, 2'd0, 2'd1, rv, ok, rdy);
        n = 0;
        while (sig_clear[0] !== 1'b1 && n < 30) begin cyc(1); n++; end
        cyc(1020);
        checks++; if (sig_clear[0] !== 1'b1) begin failures++; $display("FAIL timeout_early got=%b exp=1", sig_clear[0]); end
        cyc(10);
        checks++; if (sig_clear[0] !== 1'b0) begin failures++; $display("FAIL timeout_expired got=%b exp=0", sig_clear[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_set_and_pass();
        test_conflicts();
        test_cancel();
        test_point_freeze();
        test_async_reset();
`ifdef ROUTE_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
